decode_stage_pl: RTL and testbench

- Parametrised successor to the single-register decode stage.
- Accepts fetched instruction+PC pairs over a valid/ready handshake into a 2-entry skid buffer.
- Splits the fixed 32-bit instruction format into fields, builds an extended immediate, and computes branch targets from the PC captured with each instruction.
- Sits between the fetch stage and the register-read/execute stage; supports pipeline flush.

---
 rtl/decode_stage_pl_if.sv | 40 ++++
 rtl/decode_stage_pl.sv | 149 ++++++++++++++
 tb/tb_decode_stage_pl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pl_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and
// the register-read/execute stage.
interface decode_stage_pl_if #(
  parameter int DATA_W = 32
);
  // Upstream (fetch -> decode)
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_pc;

  // Downstream (decode -> register read / execute)
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        opcode;
  logic              i_or_reg;
  logic [3:0]        rd;
  logic [3:0]        rs1;
  logic [3:0]        rs2;
  logic [1:0]        modifier;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_ext;
  logic              is_branch;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] out_pc;

  // Decode stage side
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, opcode, i_or_reg, rd, rs1, rs2, modifier,
           imm, imm_ext, is_branch, br_target, out_pc
  );

  // Environment side: drives fetch inputs and downstream ready
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, opcode, i_or_reg, rd, rs1, rs2, modifier,
           imm, imm_ext, is_branch, br_target, out_pc
  );
endinterface

// File: rtl/decode_stage_pl.sv
// Pipelined decode stage: 2-entry skid buffer in front of registered decode
// outputs. Immediate extension and branch target are computed when an entry
// is captured so every output comes straight from a register.
module decode_stage_pl #(
  parameter int         DATA_W    = 32,
  parameter logic [4:0] BR_OPCODE = 5'd16,
  parameter int         BR_SHIFT  = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  decode_stage_pl_if.slave  bus
);

  // Main entry drives the outputs; skid entry catches one word under backpressure
  logic              r_main_valid;
  logic [31:0]       r_main_inst;
  logic [DATA_W-1:0] r_main_pc;
  logic [DATA_W-1:0] r_main_imm_ext;
  logic              r_main_is_branch;
  logic [DATA_W-1:0] r_main_br_target;

  logic              r_skid_valid;
  logic [31:0]       r_skid_inst;
  logic [DATA_W-1:0] r_skid_pc;
  logic [DATA_W-1:0] r_skid_imm_ext;
  logic              r_skid_is_branch;
  logic [DATA_W-1:0] r_skid_br_target;

  // Decode results for the word currently offered by fetch
  logic              w_in_is_branch;
  logic [DATA_W-1:0] w_in_imm_ext;
  logic [DATA_W-1:0] w_in_br_target;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_main_free;

  // Source selected for the main entry when it is free to load
  logic [31:0]       w_src_inst;
  logic [DATA_W-1:0] w_src_pc;
  logic [DATA_W-1:0] w_src_imm_ext;
  logic              w_src_is_branch;
  logic [DATA_W-1:0] w_src_br_target;

  // Ready is a pure function of skid occupancy and flush; offered words are dropped during flush
  assign w_in_ready  = !r_skid_valid && !flush;
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_main_free = !r_main_valid || bus.out_ready;

  assign w_in_is_branch = (bus.in_inst[31:27] == BR_OPCODE);

  // Extended immediate and branch target for the incoming word
  always_comb begin
    w_in_imm_ext   = '0;
    w_in_br_target = '0;
    if (w_in_is_branch) begin
      // Sign-extended 27-bit offset, scaled, added to the captured PC; wraps silently
      w_in_br_target = (DATA_W'($signed(bus.in_inst[26:0])) << BR_SHIFT) + bus.in_pc;
    end else begin
      case (bus.in_inst[17:16])
        2'b01:   w_in_imm_ext = DATA_W'($signed(bus.in_inst[15:0]));
        2'b10:   w_in_imm_ext = DATA_W'({bus.in_inst[15:0], 16'h0000});
        default: w_in_imm_ext = DATA_W'(bus.in_inst[15:0]);
      endcase
    end
  end

  // Skid entry always drains to main before any newer input
  always_comb begin
    w_src_inst      = bus.in_inst;
    w_src_pc        = bus.in_pc;
    w_src_imm_ext   = w_in_imm_ext;
    w_src_is_branch = w_in_is_branch;
    w_src_br_target = w_in_br_target;
    if (r_skid_valid) begin
      w_src_inst      = r_skid_inst;
      w_src_pc        = r_skid_pc;
      w_src_imm_ext   = r_skid_imm_ext;
      w_src_is_branch = r_skid_is_branch;
      w_src_br_target = r_skid_br_target;
    end
  end

  // Occupancy of main and skid entries; flush wins over everything but reset
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      r_main_valid <= r_skid_valid || w_in_fire;
      r_skid_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Main entry payload: reloads only when free and something is available
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_main_inst      <= '0;
      r_main_pc        <= '0;
      r_main_imm_ext   <= '0;
      r_main_is_branch <= 1'b0;
      r_main_br_target <= '0;
    end else if (!flush && w_main_free && (r_skid_valid || w_in_fire)) begin
      r_main_inst      <= w_src_inst;
      r_main_pc        <= w_src_pc;
      r_main_imm_ext   <= w_src_imm_ext;
      r_main_is_branch <= w_src_is_branch;
      r_main_br_target <= w_src_br_target;
    end
  end

  // Skid entry payload: captures the accepted word while main is held
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_skid_inst      <= '0;
      r_skid_pc        <= '0;
      r_skid_imm_ext   <= '0;
      r_skid_is_branch <= 1'b0;
      r_skid_br_target <= '0;
    end else if (!flush && !w_main_free && w_in_fire) begin
      r_skid_inst      <= bus.in_inst;
      r_skid_pc        <= bus.in_pc;
      r_skid_imm_ext   <= w_in_imm_ext;
      r_skid_is_branch <= w_in_is_branch;
      r_skid_br_target <= w_in_br_target;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.opcode    = r_main_inst[31:27];
  assign bus.i_or_reg  = r_main_inst[26];
  assign bus.rd        = r_main_inst[25:22];
  assign bus.rs1       = r_main_inst[21:18];
  assign bus.rs2       = r_main_inst[17:14];
  assign bus.modifier  = r_main_inst[17:16];
  assign bus.imm       = r_main_inst[15:0];
  assign bus.imm_ext   = r_main_imm_ext;
  assign bus.is_branch = r_main_is_branch;
  assign bus.br_target = r_main_br_target;
  assign bus.out_pc    = r_main_pc;

endmodule

// File: tb/tb_decode_stage_pl.sv
// Directed bench for decode_stage_pl: decode fields, immediate modes,
// branch targets, backpressure ordering, flush and async reset.
module tb_decode_stage_pl;

  logic clk;
  logic clr_n;
  logic flush;
  int   checks;
  int   errors;

  decode_stage_pl_if #(.DATA_W(32)) bus ();

  decode_stage_pl #(
    .DATA_W   (32),
    .BR_OPCODE(5'd16),
    .BR_SHIFT (2)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .flush(flush),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_n  = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_br_target", bus.br_target, 0);
    check("rst_out_pc",    bus.out_pc,    0);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_valid_hold", bus.out_valid, 0);

    // Forward branch
    bus.out_ready = 1'b1;
    offer(1'b1, 32'h80000003, 32'h40);
    step();
    $display("txn fwd_branch: valid=%0d target=%0h pc=%0h", bus.out_valid, bus.br_target, bus.out_pc);
    check("fb_valid",  bus.out_valid, 1);
    check("fb_isbr",   bus.is_branch, 1);
    check("fb_target", bus.br_target, 32'h4C);
    check("fb_pc",     bus.out_pc,    32'h40);
    check("fb_opcode", bus.opcode,    16);

    // Backward branch
    offer(1'b1, 32'h87FFFFFC, 32'h100);
    step();
    $display("txn bwd_branch: target=%0h imm_ext=%0h", bus.br_target, bus.imm_ext);
    check("bb_target", bus.br_target, 32'hF0);
    check("bb_immext", bus.imm_ext,   0);

    // Sign-extended immediate
    offer(1'b1, 32'h08018000, 32'h200);
    step();
    $display("txn imm_sext: op=%0d rs2=%0d mod=%0d imm_ext=%0h", bus.opcode, bus.rs2, bus.modifier, bus.imm_ext);
    check("sx_opcode", bus.opcode,    1);
    check("sx_rs2",    bus.rs2,       6);
    check("sx_mod",    bus.modifier,  1);
    check("sx_immext", bus.imm_ext,   32'hFFFF8000);
    check("sx_isbr",   bus.is_branch, 0);
    check("sx_target", bus.br_target, 0);

    // Shifted immediate
    offer(1'b1, 32'h08021234, 32'h204);
    step();
    $display("txn imm_shift: imm_ext=%0h", bus.imm_ext);
    check("sh_immext", bus.imm_ext, 32'h12340000);

    // Reserved modifier -> zero extend
    offer(1'b1, 32'h08031234, 32'h208);
    step();
    $display("txn imm_rsvd: imm_ext=%0h", bus.imm_ext);
    check("rv_immext", bus.imm_ext, 32'h00001234);

    offer(1'b0, 32'h0, 32'h0);
    step();
    check("idle_valid", bus.out_valid, 0);

    // Backpressure: A held, B into skid, C refused
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h08000001, 32'h10);
    step();
    $display("txn bp_A: valid=%0d pc=%0h ready=%0d", bus.out_valid, bus.out_pc, bus.in_ready);
    check("bpA_valid", bus.out_valid, 1);
    check("bpA_imm",   bus.imm_ext,   1);
    check("bpA_ready", bus.in_ready,  1);
    offer(1'b1, 32'h08000002, 32'h14);
    step();
    $display("txn bp_B: pc=%0h ready=%0d", bus.out_pc, bus.in_ready);
    check("bpB_pc",    bus.out_pc,   32'h10);
    check("bpB_ready", bus.in_ready, 0);
    offer(1'b1, 32'h08000003, 32'h18);
    step();
    $display("txn bp_C: pc=%0h imm=%0h ready=%0d", bus.out_pc, bus.imm_ext, bus.in_ready);
    check("bpC_pc",    bus.out_pc,   32'h10);
    check("bpC_imm",   bus.imm_ext,  1);
    check("bpC_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    $display("txn drain_B: pc=%0h imm=%0h ready=%0d", bus.out_pc, bus.imm_ext, bus.in_ready);
    check("drB_pc",    bus.out_pc,   32'h14);
    check("drB_imm",   bus.imm_ext,  2);
    check("drB_ready", bus.in_ready, 1);
    step();
    $display("txn drain_C: pc=%0h imm=%0h", bus.out_pc, bus.imm_ext);
    check("drC_pc",    bus.out_pc,    32'h18);
    check("drC_imm",   bus.imm_ext,   3);
    check("drC_valid", bus.out_valid, 1);
    offer(1'b0, 32'h0, 32'h0);
    step();
    check("drain_empty", bus.out_valid, 0);

    // Flush with both entries full and input offered
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h08000011, 32'h20);
    step();
    offer(1'b1, 32'h08000012, 32'h24);
    step();
    check("fl_pre_valid", bus.out_valid, 1);
    check("fl_pre_ready", bus.in_ready,  0);
    flush = 1'b1;
    offer(1'b1, 32'h08000013, 32'h28);
    step();
    flush = 1'b0;
    #1;
    $display("txn flush_full: valid=%0d ready=%0d", bus.out_valid, bus.in_ready);
    check("fl_valid", bus.out_valid, 0);
    check("fl_ready", bus.in_ready,  1);

    // Flush with room available: offered word must still be dropped
    flush = 1'b1;
    offer(1'b1, 32'h08000014, 32'h2C);
    #1;
    check("fl_ready_forced", bus.in_ready, 0);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    $display("txn flush_empty: valid=%0d", bus.out_valid);
    check("fl_drop_valid", bus.out_valid, 0);
    step();
    check("fl_drop_later", bus.out_valid, 0);

    // Async reset between edges with both entries full
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h80000003, 32'h40);
    step();
    offer(1'b1, 32'h08000005, 32'h44);
    step();
    check("ar_pre_target", bus.br_target, 32'h4C);
    check("ar_pre_ready",  bus.in_ready,  0);
    offer(1'b0, 32'h0, 32'h0);
    #2;
    clr_n = 1'b0;
    #1;
    $display("txn async_rst: valid=%0d target=%0h pc=%0h", bus.out_valid, bus.br_target, bus.out_pc);
    check("ar_valid",  bus.out_valid, 0);
    check("ar_target", bus.br_target, 0);
    check("ar_pc",     bus.out_pc,    0);
    check("ar_opcode", bus.opcode,    0);
    check("ar_isbr",   bus.is_branch, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check("ar_rel_ready", bus.in_ready,  1);
    check("ar_rel_valid", bus.out_valid, 0);

    // Back-to-back streaming of 8 entries
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'h08000100 + i, 32'h1000 + 4 * i);
      step();
      $display("txn stream_%0d: valid=%0d pc=%0h imm_ext=%0h ready=%0d",
               i, bus.out_valid, bus.out_pc, bus.imm_ext, bus.in_ready);
      check("st_valid", bus.out_valid, 1);
      check("st_pc",    bus.out_pc,    32'h1000 + 4 * i);
      check("st_imm",   bus.imm_ext,   32'h100 + i);
      check("st_ready", bus.in_ready,  1);
    end
    offer(1'b0, 32'h0, 32'h0);
    step();
    check("st_end_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
